// File: rtl/apx_float_add.sv
// apx_float_add -- IEEE-754 single-precision adder with configurable approximation.
//
// The block takes operand A and then operand B over stb/ack handshakes. A
// multi-cycle state machine computes A+B, and the sum is held on a stb/ack
// output port until the consumer takes it. With APX_BITS=0 the result is
// IEEE round-to-nearest-even. With APX_BITS>0 the low APX_BITS bits of both
// aligned 27-bit mantissas are cleared before the add.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   input_a / _stb / _ack          operand A handshake
//   input_b / _stb / _ack          operand B handshake
//   output_z / _stb / _ack         result handshake
//
// state   | meaning
// --------+--------------------------------------------------------------
// GET_A   | ack high, wait for operand A
// GET_B   | ack high, wait for operand B
// UNPACK  | split sign/exponent/significand, hidden bit, denormals at -126
// SPECIAL | NaN/inf/zero shortcuts straight to PUT_Z
// ALIGN   | shift smaller-exponent mantissa right 1/cycle, sticky collects
// ADD0    | apply approximation mask, add or subtract magnitudes
// ADD1    | pick 24-bit mantissa plus guard/round/sticky from the 28-bit sum
// NORM1   | shift left 1/cycle until hidden bit set or exponent hits -126
// NORM2   | shift right 1/cycle while exponent below -126
// ROUND   | round to nearest even
// PACK    | assemble the IEEE word, overflow to infinity
// PUT_Z   | present the result until it is acknowledged
module apx_float_add #(
   parameter int APX_BITS = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [3:0] {
      GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD0, ADD1,
      NORM1, NORM2, ROUND, PACK, PUT_Z
   } state_t;

   localparam logic [26:0]        APX_MASK = ~((27'd1 << APX_BITS) - 27'd1);
   localparam logic signed [9:0]  E_MIN    = -10'sd126;
   localparam logic signed [9:0]  E_MAX    = 10'sd127;

   state_t             state;
   logic [31:0]        a, b, z;
   logic [26:0]        a_m, b_m;
   logic [23:0]        z_m;
   logic signed [9:0]  a_e, b_e, z_e;
   logic               a_s, b_s, z_s;
   logic               guard, round_bit, sticky;
   logic [27:0]        sum;

   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [26:0]        a_mq, b_mq;

   assign a_nan  = (&a[30:23]) && (|a[22:0]);
   assign b_nan  = (&b[30:23]) && (|b[22:0]);
   assign a_inf  = (&a[30:23]) && !(|a[22:0]);
   assign b_inf  = (&b[30:23]) && !(|b[22:0]);
   assign a_zero = !(|a[30:0]);
   assign b_zero = !(|b[30:0]);

   // Masking happens after alignment, so the sticky bit is dropped too
   // whenever APX_BITS is nonzero.
   assign a_mq = a_m & APX_MASK;
   assign b_mq = b_m & APX_MASK;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= GET_A;
         input_a_ack  <= 1'b0;
         input_b_ack  <= 1'b0;
         output_z_stb <= 1'b0;
         output_z     <= 32'd0;
      end else begin
         case (state)
            GET_A: begin
               input_a_ack <= 1'b1;
               if (input_a_ack && input_a_stb) begin
                  a           <= input_a;
                  input_a_ack <= 1'b0;
                  state       <= GET_B;
               end
            end

            GET_B: begin
               input_b_ack <= 1'b1;
               if (input_b_ack && input_b_stb) begin
                  b           <= input_b;
                  input_b_ack <= 1'b0;
                  state       <= UNPACK;
               end
            end

            UNPACK: begin
               a_s   <= a[31];
               b_s   <= b[31];
               a_m   <= {(a[30:23] != 8'd0), a[22:0], 3'b000};
               b_m   <= {(b[30:23] != 8'd0), b[22:0], 3'b000};
               a_e   <= (a[30:23] == 8'd0) ? E_MIN : $signed({2'b00, a[30:23]}) - 10'sd127;
               b_e   <= (b[30:23] == 8'd0) ? E_MIN : $signed({2'b00, b[30:23]}) - 10'sd127;
               state <= SPECIAL;
            end

            SPECIAL: begin
               state <= PUT_Z;
               if (a_nan || b_nan) begin
                  z <= 32'hFFC0_0000;
               end else if (a_inf) begin
                  z <= (b_inf && (a[31] != b[31])) ? 32'hFFC0_0000 : {a[31], 8'hFF, 23'd0};
               end else if (b_inf) begin
                  z <= {b[31], 8'hFF, 23'd0};
               end else if (a_zero && b_zero) begin
                  z <= {a[31] & b[31], 31'd0};
               end else if (a_zero) begin
                  z <= b;
               end else if (b_zero) begin
                  z <= a;
               end else begin
                  state <= ALIGN;
               end
            end

            ALIGN: begin
               if (a_e > b_e) begin
                  b_e <= b_e + 10'sd1;
                  b_m <= {1'b0, b_m[26:1]} | {26'd0, b_m[0]};
               end else if (a_e < b_e) begin
                  a_e <= a_e + 10'sd1;
                  a_m <= {1'b0, a_m[26:1]} | {26'd0, a_m[0]};
               end else begin
                  state <= ADD0;
               end
            end

            ADD0: begin
               z_e <= a_e;
               if (a_s == b_s) begin
                  sum <= {1'b0, a_mq} + {1'b0, b_mq};
                  z_s <= a_s;
               end else if (a_mq > b_mq) begin
                  sum <= {1'b0, a_mq} - {1'b0, b_mq};
                  z_s <= a_s;
               end else if (b_mq > a_mq) begin
                  sum <= {1'b0, b_mq} - {1'b0, a_mq};
                  z_s <= b_s;
               end else begin
                  // exact cancellation gives +0
                  sum <= 28'd0;
                  z_s <= 1'b0;
               end
               state <= ADD1;
            end

            ADD1: begin
               if (sum[27]) begin
                  z_m       <= sum[27:4];
                  guard     <= sum[3];
                  round_bit <= sum[2];
                  sticky    <= sum[1] | sum[0];
                  z_e       <= z_e + 10'sd1;
               end else begin
                  z_m       <= sum[26:3];
                  guard     <= sum[2];
                  round_bit <= sum[1];
                  sticky    <= sum[0];
               end
               state <= NORM1;
            end

            NORM1: begin
               if (!z_m[23] && (z_e > E_MIN)) begin
                  z_e       <= z_e - 10'sd1;
                  z_m       <= {z_m[22:0], guard};
                  guard     <= round_bit;
                  round_bit <= 1'b0;
               end else begin
                  state <= NORM2;
               end
            end

            NORM2: begin
               if (z_e < E_MIN) begin
                  z_e       <= z_e + 10'sd1;
                  z_m       <= {1'b0, z_m[23:1]};
                  guard     <= z_m[0];
                  round_bit <= guard;
                  sticky    <= sticky | round_bit;
               end else begin
                  state <= ROUND;
               end
            end

            ROUND: begin
               if (guard && (round_bit || sticky || z_m[0])) begin
                  z_m <= z_m + 24'd1;
                  if (z_m == 24'hFF_FFFF) begin
                     z_e <= z_e + 10'sd1;
                  end
               end
               state <= PACK;
            end

            PACK: begin
               z <= {z_s, z_e[7:0] + 8'd127, z_m[22:0]};
               if ((z_e == E_MIN) && !z_m[23]) begin
                  z[30:23] <= 8'd0;
               end
               if (z_e > E_MAX) begin
                  z[30:23] <= 8'hFF;
                  z[22:0]  <= 23'd0;
               end
               state <= PUT_Z;
            end

            PUT_Z: begin
               output_z_stb <= 1'b1;
               output_z     <= z;
               if (output_z_stb && output_z_ack) begin
                  output_z_stb <= 1'b0;
                  state        <= GET_A;
               end
            end

            default: state <= GET_A;
         endcase
      end
   end

endmodule

// File: tb/tb_apx_float_add.sv
// Bench for apx_float_add: an exact instance (APX_BITS=0) and an approximate
// instance (APX_BITS=8) run side by side on the same operands. Expected sums
// come from an arbitrary-precision integer model: both operands become exact
// integers in units of 2^-149, are truncated to the approximation grain,
// combined and rounded to nearest even.
module tb_apx_float_add;

   typedef logic [289:0] big_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_a, in_b;

   logic        a_stb0, b_stb0, z_ack0, a_ack0, b_ack0, z_stb0;
   logic        a_stb8, b_stb8, z_ack8, a_ack8, b_ack8, z_stb8;
   logic [31:0] z0, z8;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   apx_float_add #(.APX_BITS(0)) u_exact (
      .clk(clk), .rst(rst),
      .input_a(in_a), .input_a_stb(a_stb0), .input_a_ack(a_ack0),
      .input_b(in_b), .input_b_stb(b_stb0), .input_b_ack(b_ack0),
      .output_z(z0), .output_z_stb(z_stb0), .output_z_ack(z_ack0)
   );

   apx_float_add #(.APX_BITS(8)) u_apx (
      .clk(clk), .rst(rst),
      .input_a(in_a), .input_a_stb(a_stb8), .input_a_ack(a_ack8),
      .input_b(in_b), .input_b_stb(b_stb8), .input_b_ack(b_ack8),
      .output_z(z8), .output_z_stb(z_stb8), .output_z_ack(z_ack8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input int apx);
      big_t ma, mb, mag, rem, half, q;
      int   ea, eb, g, p, sh, fld;
      logic s;
      logic an, bn, ai, bi, az, bz;
      an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      az = (a[30:0] == 31'd0);
      bz = (b[30:0] == 31'd0);
      if (an || bn) return 32'hFFC0_0000;
      if (ai) return (bi && (a[31] != b[31])) ? 32'hFFC0_0000 : a;
      if (bi) return b;
      if (az && bz) return {a[31] & b[31], 31'd0};
      if (az) return b;
      if (bz) return a;

      ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
      eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
      ma = big_t'({(a[30:23] != 8'd0), a[22:0]}) << (ea - 1);
      mb = big_t'({(b[30:23] != 8'd0), b[22:0]}) << (eb - 1);

      // grain of the cleared bits, relative to the larger exponent
      if (apx > 0) begin
         g = ((ea > eb) ? ea : eb) + apx - 4;
         if (g > 0) begin
            ma = ma & ~((big_t'(1) << g) - big_t'(1));
            mb = mb & ~((big_t'(1) << g) - big_t'(1));
         end
      end

      if (a[31] == b[31]) begin
         s = a[31]; mag = ma + mb;
      end else if (ma > mb) begin
         s = a[31]; mag = ma - mb;
      end else if (mb > ma) begin
         s = b[31]; mag = mb - ma;
      end else begin
         s = 1'b0; mag = '0;
      end

      if (mag == '0) return {s, 31'd0};
      p = 289;
      while (!mag[p]) p--;
      if (p < 23) return {s, 8'd0, mag[22:0]};
      sh = p - 23;
      q  = mag >> sh;
      if (sh > 0) begin
         rem  = mag & ((big_t'(1) << sh) - big_t'(1));
         half = big_t'(1) << (sh - 1);
         if ((rem > half) || ((rem == half) && q[0])) q = q + big_t'(1);
      end
      if (q[24]) begin
         q = q >> 1;
         sh++;
      end
      fld = sh + 1;
      if (fld >= 255) return {s, 8'hFF, 23'd0};
      return {s, fld[7:0], q[22:0]};
   endfunction

   // Runs one operation on both instances. hold>0 keeps the exact instance's
   // output_z_ack low for that many cycles of a presented result. abort
   // returns a few cycles after both have taken operand B.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit abort,
                         output logic [31:0] r0, output logic [31:0] r8);
      int ph0, ph8, n0, n8, held, acnt;
      bit done;
      logic [31:0] e0, e8;
      e0 = ref_add(a, b, 0);
      e8 = ref_add(a, b, 8);
      in_a = a; in_b = b;
      ph0 = 0; ph8 = 0; held = 0; acnt = 0; done = 1'b0;
      r0 = 32'hx; r8 = 32'hx;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         @(negedge clk);
         a_stb0 = (ph0 == 0);
         b_stb0 = (ph0 == 1);
         a_stb8 = (ph8 == 0);
         b_stb8 = (ph8 == 1);
         if (ph0 == 2 && z_stb0 && held < hold) begin
            chk({tag, "_hold"}, z0, e0);
            held++;
         end
         z_ack0 = (ph0 == 2) && (held >= hold) && !abort;
         z_ack8 = (ph8 == 2) && !abort;
         n0 = ph0;
         if (ph0 == 0 && a_ack0) n0 = 1;
         else if (ph0 == 1 && b_ack0) n0 = 2;
         else if (ph0 == 2 && z_stb0 && z_ack0) begin r0 = z0; n0 = 3; end
         n8 = ph8;
         if (ph8 == 0 && a_ack8) n8 = 1;
         else if (ph8 == 1 && b_ack8) n8 = 2;
         else if (ph8 == 2 && z_stb8 && z_ack8) begin r8 = z8; n8 = 3; end
         if (ph0 == 3 && ph8 == 3) done = 1'b1;
         if (abort && ph0 == 2 && ph8 == 2) begin
            acnt++;
            if (acnt >= 6) done = 1'b1;
         end
         if (!done) begin
            @(posedge clk);
            ph0 = n0;
            ph8 = n8;
         end
      end
      a_stb0 = 1'b0; b_stb0 = 1'b0; z_ack0 = 1'b0;
      a_stb8 = 1'b0; b_stb8 = 1'b0; z_ack8 = 1'b0;
      if (!abort) begin
         chk({tag, "_done"}, {31'd0, done}, 32'd1);
         chk({tag, "_exact"}, r0, e0);
         chk({tag, "_apx"}, r8, e8);
      end
   endtask

   logic [31:0] r0, r8;
   logic [31:0] da [9];
   logic [31:0] db [9];
   logic [31:0] ra, rb;
   int          e;
   logic        seen_stb;

   initial begin
      rst = 1'b1;
      in_a = 32'd0; in_b = 32'd0;
      a_stb0 = 1'b0; b_stb0 = 1'b0; z_ack0 = 1'b0;
      a_stb8 = 1'b0; b_stb8 = 1'b0; z_ack8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_ack", {31'd0, a_ack0}, 32'd0);
      chk("rst_b_ack", {31'd0, b_ack0}, 32'd0);
      chk("rst_z_stb", {31'd0, z_stb0}, 32'd0);
      chk("rst_z", z0, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("idle_a_ack", {31'd0, a_ack0}, 32'd1);
      chk("idle_b_ack", {31'd0, b_ack0}, 32'd0);

      run_op("big_plus_small", 32'h4AFF_FFFE, 32'h41A0_CCCD, 0, 1'b0, r0, r8);
      chk("big_plus_small_const", r0, 32'h4B00_0013);
      chk("single_pulse", {31'd0, z_stb0}, 32'd0);

      run_op("held_result", 32'h3F99_999A, 32'h4086_6666, 5, 1'b0, r0, r8);

      run_op("apx_lsb", 32'h3F80_0001, 32'h3F80_0000, 0, 1'b0, r0, r8);
      chk("apx_lsb_const", r8, 32'h4000_0000);
      run_op("apx_trunc", 32'h3F80_0010, 32'h3F80_0000, 0, 1'b0, r0, r8);
      chk("apx_trunc_const", r8, 32'h4000_0000);

      da = '{32'h4089_999A, 32'h7F80_0000, 32'h0000_0000, 32'h7F7F_FFFF, 32'h7FC0_1234,
             32'h8000_0000, 32'h0000_0003, 32'h3F80_0000, 32'h0080_0000};
      db = '{32'hC093_3333, 32'hFF80_0000, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h3F80_0000,
             32'h8000_0000, 32'h807F_FFFF, 32'hBF80_0000, 32'h8000_0001};
      foreach (da[i]) run_op($sformatf("directed%0d", i), da[i], db[i], 0, 1'b0, r0, r8);
      chk("neg_inf_pair", ref_add(da[1], db[1], 0) ^ 32'h0, 32'hFFC0_0000);

      // reset while the exact instance is still aligning a 23-step gap
      run_op("abort", 32'h4B00_0000, 32'h3F80_0000, 0, 1'b1, r0, r8);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_z_stb", {31'd0, z_stb0}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("abort_a_ack", {31'd0, a_ack0}, 32'd1);
      chk("abort_a_ack8", {31'd0, a_ack8}, 32'd1);
      seen_stb = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen_stb = seen_stb | z_stb0 | z_stb8;
      end
      chk("abort_no_output", {31'd0, seen_stb}, 32'd0);
      run_op("after_abort", 32'h3F80_0000, 32'h3F80_0000, 0, 1'b0, r0, r8);
      chk("after_abort_const", r0, 32'h4000_0000);

      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 3 != 0) begin
            e = int'(ra[30:23]) + int'($urandom_range(0, 30)) - 15;
            if (e < 0) e = 0;
            if (e > 254) e = 254;
            rb[30:23] = e[7:0];
            if (ra[30:23] == 8'hFF) ra[30:23] = 8'hFE;
            if (i % 3 == 2) begin
               rb[31]   = ~ra[31];
               rb[22:0] = ra[22:0] ^ (23'($urandom) & 23'h0003FF);
            end
         end
         run_op($sformatf("rand%0d", i), ra, rb, 0, 1'b0, r0, r8);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
